// File: rtl/entry_sequencer_if.sv
// Key/adder/display bundle between the debouncer, the entry sequencer and the BCD adder path.
// The master side drives keys, clear and add_done. The slave (sequencer) side drives operands and display control.
interface entry_sequencer_if #(
  parameter int unsigned NDIG = 3
);
  localparam int unsigned OPW  = 4 * NDIG;
  localparam int unsigned CNTW = $clog2(NDIG + 1);

  logic            key_valid;
  logic [3:0]      gray_in;
  logic            clear;
  logic            add_done;
  logic            add_start;
  logic [OPW-1:0]  op_a;
  logic [OPW-1:0]  op_b;
  logic [1:0]      disp_sel;
  logic [CNTW-1:0] digit_cnt;
  logic            busy;
  logic            err;

  modport master (
    output key_valid, gray_in, clear, add_done,
    input  add_start, op_a, op_b, disp_sel, digit_cnt, busy, err
  );

  modport slave (
    input  key_valid, gray_in, clear, add_done,
    output add_start, op_a, op_b, disp_sel, digit_cnt, busy, err
  );
endinterface

// File: rtl/entry_sequencer.sv
// Gray-code calculator control: builds two NDIG-digit BCD operands, starts the adder and steers the display.
// Optional add_done watchdog is enabled with `define ADD_TIMEOUT_EN.
module entry_sequencer #(
  parameter int unsigned NDIG           = 3,
  parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
  input  logic             clk,
  input  logic             rst,
  entry_sequencer_if.slave bus
);
  localparam int unsigned OPW  = 4 * NDIG;
  localparam int unsigned CNTW = $clog2(NDIG + 1);

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_START,
    S_WAIT,
    S_SHOW
  } state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  state_e          state_q;
  logic [OPW-1:0]  op_a_q;
  logic [OPW-1:0]  op_b_q;
  logic [CNTW-1:0] cnt_q;
  logic            add_start_q;
  logic [1:0]      disp_sel_q;
  logic            busy_q;
  logic            err_q;

  logic [3:0]      key_bin_c;
  logic            key_ok_c;
  logic            last_digit_c;
  logic            wd_expire_c;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    key_bin_c    = {bus.gray_in[3],
                    bus.gray_in[3] ^ bus.gray_in[2],
                    bus.gray_in[3] ^ bus.gray_in[2] ^ bus.gray_in[1],
                    ^bus.gray_in};
    key_ok_c     = (key_bin_c < 4'd10);
    last_digit_c = (cnt_q == CNTW'(NDIG - 1));
  end

`ifdef ADD_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;

  // Counts WAIT cycles; held at zero everywhere else so it restarts on each entry to WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (bus.clear || state_q != S_WAIT) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WDW'(1);
    end
  end

  assign wd_expire_c = (state_q == S_WAIT) && !bus.add_done &&
                       (wd_q == WDW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ENTER_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      add_start_q <= 1'b0;
      disp_sel_q  <= 2'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (bus.clear || wd_expire_c) begin
      // clear wins over everything; a watchdog expiry resets the same way but flags err
      state_q     <= S_ENTER_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      add_start_q <= 1'b0;
      disp_sel_q  <= 2'd0;
      busy_q      <= 1'b0;
      err_q       <= !bus.clear;
    end else begin
      add_start_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        S_ENTER_A, S_ENTER_B: begin
          if (bus.key_valid) begin
            if (!key_ok_c) begin
              err_q <= 1'b1;
            end else begin
              if (state_q == S_ENTER_A) begin
                op_a_q <= (op_a_q << 4) | OPW'(key_bin_c);
              end else begin
                op_b_q <= (op_b_q << 4) | OPW'(key_bin_c);
              end
              if (!last_digit_c) begin
                cnt_q <= cnt_q + CNTW'(1);
              end else if (state_q == S_ENTER_A) begin
                cnt_q      <= '0;
                state_q    <= S_ENTER_B;
                disp_sel_q <= 2'd1;
              end else begin
                cnt_q       <= '0;
                state_q     <= S_START;
                add_start_q <= 1'b1;
                busy_q      <= 1'b1;
              end
            end
          end
        end
        S_START: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.add_done) begin
            state_q    <= S_SHOW;
            disp_sel_q <= 2'd2;
            busy_q     <= 1'b0;
          end
        end
        S_SHOW: begin
          // The key that leaves SHOW becomes the first digit of the next operand A.
          if (bus.key_valid) begin
            if (!key_ok_c) begin
              err_q <= 1'b1;
            end else begin
              op_a_q <= OPW'(key_bin_c);
              op_b_q <= '0;
              if (NDIG == 1) begin
                state_q    <= S_ENTER_B;
                cnt_q      <= '0;
                disp_sel_q <= 2'd1;
              end else begin
                state_q    <= S_ENTER_A;
                cnt_q      <= CNTW'(1);
                disp_sel_q <= 2'd0;
              end
            end
          end
        end
        default: begin
          state_q <= S_ENTER_A;
        end
      endcase
    end
  end

  assign bus.add_start = add_start_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.disp_sel  = disp_sel_q;
  assign bus.digit_cnt = cnt_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: doc/entry_sequencer.md
Name: entry_sequencer

Overview:
- Control FSM for the Gray-code calculator datapath.
- Accepts debounced Gray-coded digit strobes and builds operand A, then operand B, as NDIG-digit packed BCD.
- Fires a one-cycle start to the BCD adder, waits for its done, then steers the 7-segment display mux to the result.
- Sits between the input debouncer and the adder/display path in module_top.

Parameters:
- NDIG, 3, digits per operand (operand width 4*NDIG).
- TIMEOUT_CYCLES, 27000000, add_done watchdog length in clk cycles (1 s at 27 MHz); used only with ADD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, 27 MHz.
- rst  input  1  asynchronous, active-low reset.
- key_valid  input  1  one-cycle strobe: gray_in holds a new digit.
- gray_in  input  4  Gray digit {ag,bg,cg,dg}, ag = MSB.
- clear  input  1  one-cycle abort strobe.
- add_done  input  1  adder completion pulse.
- add_start  output  1  one-cycle adder start pulse.
- op_a  output  4*NDIG  operand A, packed BCD, most significant digit highest.
- op_b  output  4*NDIG  operand B, packed BCD.
- disp_sel  output  2  display source: 0 = op_a, 1 = op_b, 2 = result.
- digit_cnt  output  $clog2(NDIG+1)  digits accepted for the current operand.
- busy  output  1  high in START and WAIT.
- err  output  1  one-cycle error pulse.

Behaviour:
- Reset (rst = 0, asynchronous): state ENTER_A; op_a = 0, op_b = 0, digit_cnt = 0, add_start = 0, disp_sel = 0, busy = 0, err = 0.
- All outputs are registered. Every effect appears on the clk edge after the causing input.
- Gray decode: b3 = g3, b2 = b3^g2, b1 = b2^g1, b0 = b1^g0.
- Decoded values 10–15 are invalid. A key_valid carrying an invalid value is ignored (no operand or count change) and pulses err for one cycle, in any state that accepts keys.
- ENTER_A:
  - A valid key shifts the digit in: op_a <= {op_a[4*NDIG-5:0], d}, and digit_cnt increments.
  - On the NDIG-th accepted digit: go to ENTER_B, digit_cnt = 0, disp_sel = 1.
- ENTER_B:
  - Same shifting into op_b.
  - On the NDIG-th digit: go to START, digit_cnt = 0.
- START (one cycle): add_start = 1, busy = 1; go to WAIT.
- WAIT:
  - busy = 1; key_valid is ignored (no err).
  - On add_done: go to SHOW, disp_sel = 2, busy = 0.
- SHOW:
  - op_a/op_b are held for the adder.
  - A valid key clears op_b, loads op_a = {0…, d}, sets digit_cnt = 1, disp_sel = 0, and goes to ENTER_A. The first key of the new entry is not lost.
- clear, any state: next cycle all registers take their reset values and state = ENTER_A.
  - clear has priority over a simultaneous key_valid and over add_done.
  - After clear from WAIT, a late add_done is ignored because the state is no longer WAIT.
- add_done outside WAIT is ignored.
- Simultaneous key_valid and add_done in WAIT: add_done is taken, the key is dropped.
- add_start never asserts on two consecutive cycles, and never outside START.

Optional Feature:
- Macro: ADD_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments every WAIT cycle.
  - If add_done has not arrived on the TIMEOUT_CYCLES-th WAIT cycle: err pulses once, all registers take their reset values, and state returns to ENTER_A.
  - add_done arriving on that same cycle wins; no error is raised.
- Undefined: no counter is present; WAIT holds indefinitely until add_done or clear.

Test Plan:
- Reset, then keys 0001, 0011, 0010 -> op_a = 12'h123, digit_cnt back to 0, disp_sel = 1, state ENTER_B.
- Keys 0110, 0111, 0101 -> op_b = 12'h456; add_start high exactly one cycle after the third key's register update; busy = 1.
- Key 1111 (decodes to 10) during ENTER_A with digit_cnt = 1 -> err pulse of 1 cycle; op_a and digit_cnt unchanged.
- add_done 5 cycles into WAIT -> disp_sel = 2, busy = 0. Then key 1101 -> op_a = 12'h009, op_b = 0, digit_cnt = 1, disp_sel = 0.
- clear in the same cycle as key_valid mid-entry -> all outputs 0, key dropped. clear in WAIT followed by add_done -> remains ENTER_A with disp_sel = 0.
- ADD_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and no add_done -> err pulse on the 16th WAIT cycle, return to ENTER_A. Separately, rst low mid-WAIT -> outputs reach reset values without waiting for a clk edge.
